// File: rtl/uart_pkg.sv
// UART shared package: TX FSM state type and default link timing.
// Shared by transmitter and receiver.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_DATA_WIDTH   = 8;
  localparam int UART_STOP_BITS    = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: bit_tick pulses for one cycle at count CLKS_PER_BIT-1.
// Ports: clk, rst (async high), clear (hold count at 0), bit_tick.
`timescale 1ns/1ps
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_xmt_top.sv
// UART transmitter: start, DATA_WIDTH bits LSB first, STOP_BITS stop bits.
// Ports: clk, rst (async high), tx_start/data_in in; tx_ready, tx_busy,
// tx_done, data_out (registered TX pin) out.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data.
`timescale 1ns/1ps
module uart_xmt_top
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int STOP_BITS    = UART_STOP_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  tx_ready,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  data_out
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [1:0]    LAST_STOP = 2'(STOP_BITS - 1);

  uart_tx_state_t        state;
  logic [DATA_WIDTH-1:0] shift;
  logic [BW-1:0]         bit_idx;
  logic [1:0]            stop_cnt;
  logic                  bit_tick;
  logic                  baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                  par;
`endif

  // Counter parked at 0 while idle so the start bit is a full period.
  assign baud_clr = (state == IDLE);
  assign tx_ready = (state == IDLE);
  assign tx_busy  = ~tx_ready;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (baud_clr),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_idx  <= '0;
      stop_cnt <= '0;
      data_out <= 1'b1;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_start) begin
            state    <= START;
            shift    <= data_in;
            data_out <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par      <= ^data_in;
`endif
          end
        end
        START: begin
          if (bit_tick) begin
            state    <= DATA;
            bit_idx  <= '0;
            data_out <= shift[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              data_out <= par;
`else
              state    <= STOP;
              stop_cnt <= '0;
              data_out <= 1'b1;
`endif
            end else begin
              // Pin takes the next bit as the register shifts.
              shift    <= shift >> 1;
              data_out <= shift[1];
              bit_idx  <= bit_idx + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state    <= STOP;
            stop_cnt <= '0;
            data_out <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            if (stop_cnt == LAST_STOP) begin
              state   <= IDLE;
              tx_done <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          data_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_xmt_top.sv
// Testbench for uart_xmt_top: mid-bit line checks against a frame model.
// Honours UART_TX_PARITY_EN for the expected frame layout.
`timescale 1ns/1ps
module tb_uart_xmt_top;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + 8 + P + 2;
  localparam int LEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       data_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_xmt_top #(
    .CLKS_PER_BIT(CPB),
    .DATA_WIDTH(8),
    .STOP_BITS(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .data_in  (data_in),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .data_out (data_out)
  );

  // Expected line level of serial bit k of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (P == 1 && k == 9) return (ones % 2) == 1;
    return 1'b1;
  endfunction

  // Called right at the accept edge; ends at the tx_done negedge.
  task automatic check_frame(input logic [7:0] b, input bit hold,
                             input logic [7:0] nxt, input int inject);
    int dones;
    logic e;
    dones = 0;
    #1;
    checks++;
    if (data_out !== 1'b0 || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL accept b=%h data_out=%b busy=%b want 0/1",
               b, data_out, tx_busy);
    end
    for (int j = 0; j <= LEN; j++) begin
      @(negedge clk);
      if (j == 0) begin
        if (hold) data_in = nxt;
        else tx_start = 1'b0;
      end
      if (j == inject) begin
        tx_start = 1'b1;
        data_in = 8'hFF;
      end
      if (inject >= 0 && j == inject + 1) tx_start = 1'b0;
      if (j < LEN) begin
        if (tx_done === 1'b1) dones++;
        if (j % CPB == CPB / 2) begin
          e = exp_bit(b, j / CPB);
          checks++;
          if (data_out !== e) begin
            failures++;
            $display("FAIL line b=%h bit=%0d got=%b want=%b",
                     b, j / CPB, data_out, e);
          end
        end
      end else begin
        checks++;
        if (tx_done !== 1'b1 || tx_ready !== 1'b1 ||
            data_out !== 1'b1 || dones !== 0) begin
          failures++;
          $display("FAIL done b=%h done=%b ready=%b line=%b early=%0d want 1/1/1/0",
                   b, tx_done, tx_ready, data_out, dones);
        end
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int inject);
    @(negedge clk);
    tx_start = 1'b1;
    data_in = b;
    @(posedge clk);
    check_frame(b, 1'b0, 8'h00, inject);
  endtask

  task automatic check_done_drop(input string nm);
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0) begin
      failures++;
      $display("FAIL %s done_width got=%b want=0", nm, tx_done);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    #1 rst = 1'b1;
    for (int i = 0; i < 15000; i++) begin
      @(negedge clk);
      tx_start = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      if (data_out !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset bad_cycles got=%0d want=0", bad);
    end
    tx_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    send(8'hA5, -1);
    check_done_drop("single");
  endtask

  task automatic test_busy_ignore();
    int bad;
    bad = 0;
    send(8'h3C, 5 * CPB + 3);
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (data_out !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL busy_ignore idle_after got=%0d bad want=0", bad);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    tx_start = 1'b1;
    data_in = 8'h00;
    @(posedge clk);
    check_frame(8'h00, 1'b1, 8'hFF, -1);
    @(posedge clk);
    check_frame(8'hFF, 1'b0, 8'h00, -1);
    check_done_drop("b2b");
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    @(negedge clk);
    tx_start = 1'b1;
    data_in = 8'h55;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    repeat (4 * CPB + CPB / 2 - 1) @(negedge clk);
    checks++;
    if (data_out !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid pre_bit3 got=%b want=0", data_out);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 1'b1 || tx_ready !== 1'b1 || tx_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid async line=%b ready=%b done=%b want 1/1/0",
               data_out, tx_ready, tx_done);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2 * LEN; i++) begin
      @(negedge clk);
      if (data_out !== 1'b1 || tx_done !== 1'b0 || tx_ready !== 1'b1)
        bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rst_mid abandoned got=%0d bad want=0", bad);
    end
    send(8'h81, -1);
    check_done_drop("after_rst");
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      send(b, -1);
      check_done_drop("random");
    end
  endtask

  task automatic test_parity();
    send(8'h07, -1);
    check_done_drop("par07");
    send(8'h03, -1);
    check_done_drop("par03");
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_parity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
